// File: rtl/rvx_bus_arbiter.sv
// rvx_bus_arbiter: shares one memory port between the instruction bus
// (read-only) and the data bus (read/write). Each port gets one capture
// slot. Grants are round-robin and only one memory transaction is
// outstanding at a time. Responses are routed back to the owning port
// combinationally.
module rvx_bus_arbiter #(
  parameter logic DBUS_FIRST = 1'b1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ibus_address,
  input  logic        ibus_rrequest,
  output logic [31:0] ibus_rdata,
  output logic        ibus_rresponse,
  input  logic [31:0] dbus_address,
  input  logic        dbus_rrequest,
  input  logic        dbus_wrequest,
  input  logic [31:0] dbus_wdata,
  input  logic [3:0]  dbus_wstrobe,
  output logic [31:0] dbus_rdata,
  output logic        dbus_rresponse,
  output logic        dbus_wresponse,
  output logic [31:0] mem_address,
  output logic        mem_rrequest,
  output logic        mem_wrequest,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrobe,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rresponse,
  input  logic        mem_wresponse
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] BUSY_I = 2'd1;
  localparam logic [1:0] BUSY_D = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic        busy;
  logic        busy_write;   // type of the transaction currently on the memory port
  logic        last_grant;   // 1: dbus was granted last, 0: ibus

  // per-port capture slots
  logic        ibus_pending;
  logic [31:0] ibus_slot_address;
  logic        dbus_pending;
  logic        dbus_slot_write;
  logic [31:0] dbus_slot_address;
  logic [31:0] dbus_slot_wdata;
  logic [3:0]  dbus_slot_wstrobe;

  logic        ibus_new;
  logic        dbus_new;
  logic        owner_done;
  logic        free;
  logic        ibus_candidate;
  logic        dbus_candidate;
  logic        grant_i;
  logic        grant_d;

  // slot contents if pending, otherwise the request presented this cycle
  logic [31:0] ibus_src_address;
  logic        dbus_src_write;
  logic [31:0] dbus_src_address;
  logic [31:0] dbus_src_wdata;
  logic [3:0]  dbus_src_wstrobe;

  // response routing and memory-side request levels
  always_comb begin
    busy           = (state == BUSY_I) || (state == BUSY_D);
    ibus_rdata     = mem_rdata;
    dbus_rdata     = mem_rdata;
    ibus_rresponse = (state == BUSY_I) & mem_rresponse;
    dbus_rresponse = (state == BUSY_D) & ~busy_write & mem_rresponse;
    dbus_wresponse = (state == BUSY_D) & busy_write & mem_wresponse;
    mem_rrequest   = busy & ~busy_write & ~mem_rresponse;
    mem_wrequest   = busy & busy_write & ~mem_wresponse;
  end

  // capture qualification and round-robin arbitration
  always_comb begin
    owner_done     = ibus_rresponse | dbus_rresponse | dbus_wresponse;
    ibus_new       = ibus_rrequest &
                     (~(ibus_pending | (state == BUSY_I)) | ibus_rresponse);
    dbus_new       = (dbus_rrequest | dbus_wrequest) &
                     (~(dbus_pending | (state == BUSY_D)) | dbus_rresponse | dbus_wresponse);
    free           = ~busy | owner_done;
    ibus_candidate = ibus_pending | ibus_new;
    dbus_candidate = dbus_pending | dbus_new;
    grant_d        = free & dbus_candidate & (~ibus_candidate | ~last_grant);
    grant_i        = free & ibus_candidate & ~grant_d;

    ibus_src_address = ibus_pending ? ibus_slot_address : ibus_address;
    dbus_src_write   = dbus_pending ? dbus_slot_write   : dbus_wrequest;
    dbus_src_address = dbus_pending ? dbus_slot_address : dbus_address;
    dbus_src_wdata   = dbus_pending ? dbus_slot_wdata   : dbus_wdata;
    dbus_src_wstrobe = dbus_pending ? dbus_slot_wstrobe : dbus_wstrobe;

    state_next = state;
    if (free) begin
      if (grant_i)      state_next = BUSY_I;
      else if (grant_d) state_next = BUSY_D;
      else              state_next = IDLE;
    end
  end

  // FSM, grant history and issued memory transaction registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      busy_write  <= 1'b0;
      last_grant  <= ~DBUS_FIRST;
      mem_address <= '0;
      mem_wdata   <= '0;
      mem_wstrobe <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        last_grant  <= 1'b0;
        busy_write  <= 1'b0;
        mem_address <= ibus_src_address;
      end else if (grant_d) begin
        last_grant  <= 1'b1;
        busy_write  <= dbus_src_write;
        mem_address <= dbus_src_address;
        mem_wdata   <= dbus_src_wdata;
        mem_wstrobe <= dbus_src_wstrobe;
      end
    end
  end

  // per-port capture slots; a slot drains when its contents are granted
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ibus_pending      <= 1'b0;
      ibus_slot_address <= '0;
      dbus_pending      <= 1'b0;
      dbus_slot_write   <= 1'b0;
      dbus_slot_address <= '0;
      dbus_slot_wdata   <= '0;
      dbus_slot_wstrobe <= '0;
    end else begin
      if (grant_i) begin
        ibus_pending <= 1'b0;
      end else if (ibus_new) begin
        ibus_pending      <= 1'b1;
        ibus_slot_address <= ibus_address;
      end
      // a simultaneous load+store request is kept as the store only
      if (grant_d) begin
        dbus_pending <= 1'b0;
      end else if (dbus_new) begin
        dbus_pending      <= 1'b1;
        dbus_slot_write   <= dbus_wrequest;
        dbus_slot_address <= dbus_address;
        dbus_slot_wdata   <= dbus_wdata;
        dbus_slot_wstrobe <= dbus_wstrobe;
      end
    end
  end

endmodule

// File: tb/tb_rvx_bus_arbiter.sv
// Testbench for rvx_bus_arbiter: directed scenarios followed by a randomized
// phase. All of it is checked every cycle against a transaction-level model.
module tb_rvx_bus_arbiter;

  localparam logic DBUS_FIRST = 1'b1;

  logic        clock = 1'b0;
  logic        reset;
  logic [31:0] ibus_address;
  logic        ibus_rrequest;
  logic [31:0] ibus_rdata;
  logic        ibus_rresponse;
  logic [31:0] dbus_address;
  logic        dbus_rrequest;
  logic        dbus_wrequest;
  logic [31:0] dbus_wdata;
  logic [3:0]  dbus_wstrobe;
  logic [31:0] dbus_rdata;
  logic        dbus_rresponse;
  logic        dbus_wresponse;
  logic [31:0] mem_address;
  logic        mem_rrequest;
  logic        mem_wrequest;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrobe;
  logic [31:0] mem_rdata;
  logic        mem_rresponse;
  logic        mem_wresponse;

  rvx_bus_arbiter #(.DBUS_FIRST(DBUS_FIRST)) dut (
    .clock(clock), .reset(reset),
    .ibus_address(ibus_address), .ibus_rrequest(ibus_rrequest),
    .ibus_rdata(ibus_rdata), .ibus_rresponse(ibus_rresponse),
    .dbus_address(dbus_address), .dbus_rrequest(dbus_rrequest),
    .dbus_wrequest(dbus_wrequest), .dbus_wdata(dbus_wdata),
    .dbus_wstrobe(dbus_wstrobe), .dbus_rdata(dbus_rdata),
    .dbus_rresponse(dbus_rresponse), .dbus_wresponse(dbus_wresponse),
    .mem_address(mem_address), .mem_rrequest(mem_rrequest),
    .mem_wrequest(mem_wrequest), .mem_wdata(mem_wdata),
    .mem_wstrobe(mem_wstrobe), .mem_rdata(mem_rdata),
    .mem_rresponse(mem_rresponse), .mem_wresponse(mem_wresponse)
  );

  always #5 clock = ~clock;

  int unsigned tests = 0;
  int unsigned fails = 0;

  // reference model: one transaction record per waiting port, one on the memory
  typedef struct {
    bit          valid;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } txn_t;

  txn_t        slot[2];      // 0: ibus, 1: dbus -- captured, not yet on the memory
  txn_t        act;          // transaction presently on the memory port
  int          act_port;
  int          last_port;
  int unsigned wait_cnt;     // cycles before the bench memory answers

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    return $urandom() & 32'hFFFF_FFFC;
  endfunction

  task automatic model_reset();
    slot[0].valid = 1'b0;
    slot[1].valid = 1'b0;
    act.valid     = 1'b0;
    act_port      = 0;
    last_port     = DBUS_FIRST ? 0 : 1;
  endtask

  // advance the model across one clock edge using the inputs currently driven
  task automatic model_edge();
    bit   resp;
    bit   req[2];
    bit   has[2];
    txn_t nt[2];
    int   pick;
    resp   = act.valid && (act.wr ? mem_wresponse : mem_rresponse);
    req[0] = ibus_rrequest;
    req[1] = dbus_rrequest || dbus_wrequest;
    nt[0]  = '{valid: 1'b1, wr: 1'b0, addr: ibus_address, wdata: 32'h0, strb: 4'h0};
    nt[1]  = '{valid: 1'b1, wr: dbus_wrequest, addr: dbus_address,
               wdata: dbus_wdata, strb: dbus_wstrobe};
    for (int p = 0; p < 2; p++) begin
      has[p] = slot[p].valid || (act.valid && act_port == p && !resp);
      if (req[p] && !has[p]) slot[p] = nt[p];
    end
    if (resp) act.valid = 1'b0;
    if (!act.valid) begin
      pick = -1;
      if (slot[0].valid && slot[1].valid) pick = (last_port == 0) ? 1 : 0;
      else if (slot[0].valid)             pick = 0;
      else if (slot[1].valid)             pick = 1;
      if (pick >= 0) begin
        act           = slot[pick];
        act_port      = pick;
        slot[pick].valid = 1'b0;
        last_port     = pick;
        wait_cnt      = $urandom_range(0, 3);
      end
    end
  endtask

  // outputs the model predicts for the current cycle
  task automatic check_cycle();
    bit own_i;
    bit own_d;
    own_i = act.valid && act_port == 0;
    own_d = act.valid && act_port == 1;
    chk1("mem_rrequest",   mem_rrequest,   act.valid && !act.wr && !mem_rresponse);
    chk1("mem_wrequest",   mem_wrequest,   act.valid && act.wr && !mem_wresponse);
    chk1("ibus_rresponse", ibus_rresponse, own_i && mem_rresponse);
    chk1("dbus_rresponse", dbus_rresponse, own_d && !act.wr && mem_rresponse);
    chk1("dbus_wresponse", dbus_wresponse, own_d && act.wr && mem_wresponse);
    chk32("ibus_rdata", ibus_rdata, mem_rdata);
    chk32("dbus_rdata", dbus_rdata, mem_rdata);
    if (act.valid) begin
      chk32("mem_address", mem_address, act.addr);
      if (act.wr) begin
        chk32("mem_wdata", mem_wdata, act.wdata);
        chk32("mem_wstrobe", {28'h0, mem_wstrobe}, {28'h0, act.strb});
      end
    end
  endtask

  task automatic mid_step();
    #4;
    if (reset) model_reset();
    check_cycle();
  endtask

  task automatic edge_step();
    if (reset) model_reset();
    else       model_edge();
    @(posedge clock);
    #1;
  endtask

  bit i_hold;
  bit d_hold;
  bit ri;
  bit rd;
  int unsigned k;

  initial begin
    reset = 1'b1;
    ibus_rrequest = 1'b1; ibus_address = 32'h100;
    dbus_rrequest = 1'b0; dbus_wrequest = 1'b0;
    dbus_address = 32'h0; dbus_wdata = 32'h0; dbus_wstrobe = 4'h0;
    mem_rdata = 32'h0; mem_rresponse = 1'b0; mem_wresponse = 1'b0;
    wait_cnt = 0;
    model_reset();
    @(posedge clock); #1;

    // reset held with a fetch pending, then fetch 0x100 answered with 0x13
    mid_step();
    chk32("rst_mem_address", mem_address, 32'h0);
    chk32("rst_mem_wdata", mem_wdata, 32'h0);
    chk32("rst_mem_wstrobe", {28'h0, mem_wstrobe}, 32'h0);
    chk1("rst_mem_rrequest", mem_rrequest, 1'b0);
    chk1("rst_mem_wrequest", mem_wrequest, 1'b0);
    edge_step();
    reset = 1'b0;
    mid_step();
    chk1("capture_mem_rrequest", mem_rrequest, 1'b0);
    edge_step();
    mid_step();
    chk1("issue_mem_rrequest", mem_rrequest, 1'b1);
    chk32("issue_mem_address", mem_address, 32'h100);
    edge_step();
    mid_step();
    edge_step();
    mem_rresponse = 1'b1; mem_rdata = 32'h0000_0013; ibus_rrequest = 1'b0;
    mid_step();
    chk1("fetch_ibus_rresponse", ibus_rresponse, 1'b1);
    chk32("fetch_ibus_rdata", ibus_rdata, 32'h13);
    chk1("fetch_dbus_rresponse", dbus_rresponse, 1'b0);
    chk1("fetch_dbus_wresponse", dbus_wresponse, 1'b0);
    edge_step();
    mem_rresponse = 1'b0;

    // dbus load outstanding, one-cycle reset, then a stale memory response
    dbus_rrequest = 1'b1; dbus_address = 32'h300;
    mid_step(); edge_step();
    mid_step();
    chk1("stale_issue_rrequest", mem_rrequest, 1'b1);
    edge_step();
    reset = 1'b1; dbus_rrequest = 1'b0;
    mid_step();
    chk1("stale_rst_rrequest", mem_rrequest, 1'b0);
    chk32("stale_rst_address", mem_address, 32'h0);
    edge_step();
    reset = 1'b0; mem_rresponse = 1'b1;
    mid_step();
    chk1("stale_dbus_rresponse", dbus_rresponse, 1'b0);
    chk1("stale_ibus_rresponse", ibus_rresponse, 1'b0);
    edge_step();
    mem_rresponse = 1'b0;
    mid_step();
    chk1("stale_idle_rrequest", mem_rrequest, 1'b0);
    chk1("stale_idle_wrequest", mem_wrequest, 1'b0);
    edge_step();

    // first tie after reset: write wins, then re-requested write loses the next tie
    ibus_rrequest = 1'b1; ibus_address = 32'h100;
    dbus_wrequest = 1'b1; dbus_address = 32'h2000;
    dbus_wdata = 32'hDEAD_BEEF; dbus_wstrobe = 4'hF;
    mid_step(); edge_step();
    mid_step();
    chk1("tie_wr_first", mem_wrequest, 1'b1);
    chk1("tie_no_read_yet", mem_rrequest, 1'b0);
    chk32("tie_wr_address", mem_address, 32'h2000);
    chk32("tie_wr_wdata", mem_wdata, 32'hDEAD_BEEF);
    chk32("tie_wr_wstrobe", {28'h0, mem_wstrobe}, 32'hF);
    edge_step();
    mem_wresponse = 1'b1; dbus_address = 32'h2004; dbus_wdata = 32'h1234_5678;
    mid_step();
    chk1("tie_dbus_wresponse", dbus_wresponse, 1'b1);
    chk1("tie_wr_dropped", mem_wrequest, 1'b0);
    edge_step();
    mem_wresponse = 1'b0;
    mid_step();
    chk1("tie_rd_next", mem_rrequest, 1'b1);
    chk32("tie_rd_address", mem_address, 32'h100);
    chk1("tie_wr_waits", mem_wrequest, 1'b0);
    edge_step();
    mem_rresponse = 1'b1; ibus_rrequest = 1'b0;
    mid_step();
    chk1("tie_ibus_rresponse", ibus_rresponse, 1'b1);
    edge_step();
    mem_rresponse = 1'b0;
    mid_step();
    chk1("tie_second_wr", mem_wrequest, 1'b1);
    chk32("tie_second_address", mem_address, 32'h2004);
    chk32("tie_second_wdata", mem_wdata, 32'h1234_5678);
    edge_step();
    mem_wresponse = 1'b1; dbus_wrequest = 1'b0;
    mid_step();
    chk1("tie_second_wresponse", dbus_wresponse, 1'b1);
    edge_step();
    mem_wresponse = 1'b0;
    mid_step();
    chk1("tie_idle_rrequest", mem_rrequest, 1'b0);
    chk1("tie_idle_wrequest", mem_wrequest, 1'b0);
    edge_step();

    // back-to-back fetches 0x0 then 0x4
    ibus_rrequest = 1'b1; ibus_address = 32'h0;
    mid_step(); edge_step();
    mid_step();
    chk32("b2b_first_address", mem_address, 32'h0);
    chk1("b2b_first_rrequest", mem_rrequest, 1'b1);
    edge_step();
    mem_rresponse = 1'b1; ibus_address = 32'h4;
    mid_step();
    chk1("b2b_first_rresponse", ibus_rresponse, 1'b1);
    edge_step();
    mem_rresponse = 1'b0;
    mid_step();
    chk32("b2b_second_address", mem_address, 32'h4);
    chk1("b2b_second_rrequest", mem_rrequest, 1'b1);
    edge_step();
    mem_rresponse = 1'b1; ibus_rrequest = 1'b0;
    mid_step();
    chk1("b2b_second_rresponse", ibus_rresponse, 1'b1);
    edge_step();
    mem_rresponse = 1'b0;
    mid_step();
    chk1("b2b_no_duplicate", mem_rrequest, 1'b0);
    edge_step();

    // load and store together at 0x40: only the store reaches memory
    dbus_rrequest = 1'b1; dbus_wrequest = 1'b1; dbus_address = 32'h40;
    dbus_wdata = 32'hA5A5_A5A5; dbus_wstrobe = 4'h3;
    mid_step(); edge_step();
    mid_step();
    chk1("rw_wrequest", mem_wrequest, 1'b1);
    chk1("rw_no_rrequest", mem_rrequest, 1'b0);
    chk32("rw_address", mem_address, 32'h40);
    chk32("rw_wstrobe", {28'h0, mem_wstrobe}, 32'h3);
    edge_step();
    mem_wresponse = 1'b1; dbus_rrequest = 1'b0; dbus_wrequest = 1'b0;
    mid_step();
    chk1("rw_wresponse", dbus_wresponse, 1'b1);
    chk1("rw_no_rresponse", dbus_rresponse, 1'b0);
    edge_step();
    mem_wresponse = 1'b0;
    mid_step();
    chk1("rw_after_rrequest", mem_rrequest, 1'b0);
    chk1("rw_after_wrequest", mem_wrequest, 1'b0);
    edge_step();

    // randomized traffic with random memory latency and stray responses
    i_hold = 1'b0;
    d_hold = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      mem_rresponse = 1'b0;
      mem_wresponse = 1'b0;
      mem_rdata     = $urandom();
      if (act.valid) begin
        if (wait_cnt == 0) begin
          if (act.wr) mem_wresponse = 1'b1;
          else        mem_rresponse = 1'b1;
        end else begin
          wait_cnt--;
          if ($urandom_range(0, 7) == 0) begin
            if (act.wr) mem_rresponse = 1'b1;
            else        mem_wresponse = 1'b1;
          end
        end
      end else if ($urandom_range(0, 7) == 0) begin
        mem_rresponse = 1'b1;
      end
      ri = act.valid && act_port == 0 && mem_rresponse;
      rd = act.valid && act_port == 1 && (act.wr ? mem_wresponse : mem_rresponse);

      if (i_hold) begin
        if (ri) begin
          if ($urandom_range(0, 1) == 1) ibus_address = rand_addr();
          else begin ibus_rrequest = 1'b0; i_hold = 1'b0; end
        end
      end else if ($urandom_range(0, 2) == 0) begin
        ibus_rrequest = 1'b1; ibus_address = rand_addr(); i_hold = 1'b1;
      end

      if ((d_hold && rd && $urandom_range(0, 1) == 1) ||
          (!d_hold && $urandom_range(0, 2) == 0)) begin
        k = $urandom_range(0, 4);
        dbus_rrequest = (k < 2) || (k == 4);
        dbus_wrequest = (k >= 2);
        dbus_address  = rand_addr();
        dbus_wdata    = $urandom();
        dbus_wstrobe  = 4'($urandom_range(0, 15));
        d_hold        = 1'b1;
      end else if (d_hold && rd) begin
        dbus_rrequest = 1'b0; dbus_wrequest = 1'b0; d_hold = 1'b0;
      end

      mid_step();
      edge_step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
